// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the LSU.
// It allows one outstanding transaction and reissues in the same cycle as a response.
module mem_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_INSTR = 2'd1, OWN_DATA = 2'd2} owner_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_DATA_BURST);

  state_e      state_q, state_d;
  logic        lock_q, lock_d;
  owner_e      lock_owner_q, lock_owner_d;
  owner_e      resp_owner_q, resp_owner_d;
  logic [3:0]  streak_q, streak_d;

  owner_e      sel;
  logic        issue_ok;
  logic        rsp_fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      lock_q       <= 1'b0;
      lock_owner_q <= OWN_NONE;
      resp_owner_q <= OWN_NONE;
      streak_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      resp_owner_q <= resp_owner_d;
      streak_q     <= streak_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    resp_owner_d = resp_owner_q;
    streak_d     = streak_q;

    if (rsp_fire) begin
      state_d      = ST_IDLE;
      resp_owner_d = OWN_NONE;
    end

    if (mem_req_o) begin
      if (mem_gnt_i) begin
        state_d      = ST_RESP;
        resp_owner_d = sel;
        lock_d       = 1'b0;
        lock_owner_d = OWN_NONE;
      end else begin
        lock_d       = 1'b1;
        lock_owner_d = sel;
      end
    end

    // Streak only counts data wins that actually kept a waiting fetch out.
    if (!instr_req_i || instr_gnt_o) begin
      streak_d = 4'd0;
    end else if (data_gnt_o && (streak_q < MaxBurst)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_comb begin
    // Outputs are forced quiet while reset is held, including the rdata pass-through.
    issue_ok = rst_ni && ((state_q == ST_IDLE) || mem_rvalid_i);
    rsp_fire = (state_q == ST_RESP) && mem_rvalid_i;

    sel = OWN_NONE;
    if (issue_ok) begin
      if (lock_q) begin
        sel = lock_owner_q;
      end else if (data_req_i && !(instr_req_i && (streak_q == MaxBurst))) begin
        sel = OWN_DATA;
      end else if (instr_req_i) begin
        sel = OWN_INSTR;
      end
    end

    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    case (sel)
      OWN_INSTR: begin
        mem_req_o  = 1'b1;
        mem_be_o   = 4'hF;
        mem_addr_o = instr_addr_i;
      end
      OWN_DATA: begin
        mem_req_o   = 1'b1;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end
      default: ;
    endcase

    instr_gnt_o    = mem_req_o && mem_gnt_i && (sel == OWN_INSTR);
    data_gnt_o     = mem_req_o && mem_gnt_i && (sel == OWN_DATA);
    instr_rvalid_o = rsp_fire && (resp_owner_q == OWN_INSTR);
    data_rvalid_o  = rsp_fire && (resp_owner_q == OWN_DATA);
    instr_rdata_o  = rst_ni ? mem_rdata_i : 32'h0;
    data_rdata_o   = rst_ni ? mem_rdata_i : 32'h0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int MAXB = 4;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        ireq, dreq, dwe, mgnt, mrv;
  logic [31:0] iaddr, daddr, dwdata, mrdata;
  logic [3:0]  dbe;

  logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
  logic [31:0] instr_rdata_o, data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.MAX_DATA_BURST(MAXB)) dut (
    .clk_i(clk_i), .rst_ni(rst_n),
    .instr_req_i(ireq), .instr_addr_i(iaddr),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(dreq), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(daddr), .data_wdata_i(dwdata),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mgnt), .mem_rvalid_i(mrv), .mem_rdata_i(mrdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who is waiting for a response, who is stuck waiting for a grant,
  // and how many data grants in a row a waiting fetch has watched go by.
  bit m_busy;
  int m_resp, m_pend, m_run, who;

  logic        e_req, e_we, e_igr, e_dgr, e_irv, e_drv;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_rdata;

  logic        obs_req, obs_we, obs_igr, obs_dgr, obs_irv, obs_drv;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_irdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit can_issue;
    can_issue = rst_n && (!m_busy || mrv);
    who = 0;
    if (can_issue) begin
      if (m_pend != 0) who = m_pend;
      else if (dreq && !(ireq && m_run >= MAXB)) who = 2;
      else if (ireq) who = 1;
    end
    e_req   = (who != 0);
    e_addr  = (who == 2) ? daddr : (who == 1) ? iaddr : 32'h0;
    e_we    = (who == 2) && dwe;
    e_be    = (who == 2) ? dbe : (who == 1) ? 4'hF : 4'h0;
    e_wdata = (who == 2) ? dwdata : 32'h0;
    e_igr   = (who == 1) && mgnt;
    e_dgr   = (who == 2) && mgnt;
    e_irv   = rst_n && m_busy && mrv && (m_resp == 1);
    e_drv   = rst_n && m_busy && mrv && (m_resp == 2);
    e_rdata = rst_n ? mrdata : 32'h0;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_busy = 0; m_resp = 0; m_pend = 0; m_run = 0;
    end else begin
      if (m_busy && mrv) m_busy = 0;
      if (who != 0) begin
        if (mgnt) begin
          m_busy = 1; m_resp = who; m_pend = 0;
        end else begin
          m_pend = who;
        end
      end
      if (!ireq || e_igr) m_run = 0;
      else if (e_dgr) m_run = (m_run + 1 > MAXB) ? MAXB : m_run + 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk_i);
    model_eval();
    obs_req = mem_req_o; obs_we = mem_we_o; obs_be = mem_be_o; obs_addr = mem_addr_o;
    obs_igr = instr_gnt_o; obs_dgr = data_gnt_o;
    obs_irv = instr_rvalid_o; obs_drv = data_rvalid_o; obs_irdata = instr_rdata_o;
    check_eq("mem_req",   32'(mem_req_o),      32'(e_req));
    check_eq("mem_we",    32'(mem_we_o),       32'(e_we));
    check_eq("mem_be",    32'(mem_be_o),       32'(e_be));
    check_eq("mem_addr",  mem_addr_o,          e_addr);
    check_eq("mem_wdata", mem_wdata_o,         e_wdata);
    check_eq("instr_gnt", 32'(instr_gnt_o),    32'(e_igr));
    check_eq("data_gnt",  32'(data_gnt_o),     32'(e_dgr));
    check_eq("instr_rv",  32'(instr_rvalid_o), 32'(e_irv));
    check_eq("data_rv",   32'(data_rvalid_o),  32'(e_drv));
    check_eq("instr_rd",  instr_rdata_o,       e_rdata);
    check_eq("data_rd",   data_rdata_o,        e_rdata);
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    ireq = 0; iaddr = 0; dreq = 0; dwe = 0; dbe = 0; daddr = 0; dwdata = 0;
    mgnt = 0; mrv = 0; mrdata = 0;
  endtask

  bit          ip, dp, mem_busy;
  int          mem_cnt;
  logic [9:0]  pattern;

  initial begin
    m_busy = 0; m_resp = 0; m_pend = 0; m_run = 0; who = 0;
    rst_n = 0;
    idle_inputs();
    ireq = 1; iaddr = 32'h0000_0ABC; dreq = 1; daddr = 32'h44; mgnt = 1; mrv = 1;
    mrdata = 32'h1234_5678;
    cycle();
    check_eq("rst_req", 32'(obs_req), 32'd0);
    check_eq("rst_rdata", obs_irdata, 32'd0);
    cycle();
    rst_n = 1; idle_inputs();
    cycle();

    // single fetch
    ireq = 1; iaddr = 32'h100; mgnt = 1;
    cycle();
    check_eq("fetch_gnt", 32'(obs_igr), 32'd1);
    ireq = 0; mgnt = 0;
    cycle();
    check_eq("fetch_rv_early", 32'(obs_irv), 32'd0);
    mrv = 1; mrdata = 32'h0050_0093;
    cycle();
    check_eq("fetch_rv", 32'(obs_irv), 32'd1);
    check_eq("fetch_no_drv", 32'(obs_drv), 32'd0);
    check_eq("fetch_rdata", obs_irdata, 32'h0050_0093);
    mrv = 0;
    cycle();

    // simultaneous requests: the store wins
    ireq = 1; iaddr = 32'h104; dreq = 1; dwe = 1; daddr = 32'h200;
    dwdata = 32'hDEAD_BEEF; dbe = 4'b0011; mgnt = 1;
    cycle();
    check_eq("sim_dgr", 32'(obs_dgr), 32'd1);
    check_eq("sim_we", 32'(obs_we), 32'd1);
    check_eq("sim_be", 32'(obs_be), 32'h3);
    check_eq("sim_igr_first", 32'(obs_igr), 32'd0);
    dreq = 0; dwe = 0; dbe = 0; daddr = 0; dwdata = 0;
    cycle();
    check_eq("sim_igr_wait", 32'(obs_igr), 32'd0);
    mrv = 1;
    cycle();
    check_eq("sim_drv", 32'(obs_drv), 32'd1);
    check_eq("sim_igr", 32'(obs_igr), 32'd1);
    ireq = 0;
    cycle();
    check_eq("sim_irv", 32'(obs_irv), 32'd1);
    mrv = 0;
    cycle();

    // lock: stalled fetch holds the port against a later data request
    ireq = 1; iaddr = 32'h300; mgnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin dreq = 1; daddr = 32'h400; dbe = 4'hF; end
      cycle();
      check_eq("lock_addr", obs_addr, 32'h300);
      check_eq("lock_no_dgr", 32'(obs_dgr), 32'd0);
    end
    mgnt = 1;
    cycle();
    check_eq("lock_igr", 32'(obs_igr), 32'd1);
    ireq = 0;
    cycle();
    check_eq("lock_dgr_wait", 32'(obs_dgr), 32'd0);
    mrv = 1;
    cycle();
    check_eq("lock_irv", 32'(obs_irv), 32'd1);
    check_eq("lock_dgr", 32'(obs_dgr), 32'd1);
    dreq = 0;
    cycle();
    check_eq("lock_drv", 32'(obs_drv), 32'd1);
    mrv = 0;
    cycle();

    // starvation guard with single-cycle memory
    ireq = 1; iaddr = 32'h600; dreq = 1; daddr = 32'h700; dwe = 0; dbe = 4'hF; mgnt = 1;
    pattern = '0;
    for (int i = 0; i < 10; i++) begin
      mrv = (i > 0);
      cycle();
      pattern[i] = obs_igr;
      check_eq("starve_one_gnt", 32'(obs_igr ^ obs_dgr), 32'd1);
    end
    check_eq("starve_pattern", 32'(pattern), 32'h210);
    ireq = 0; dreq = 0; mrv = 1;
    cycle();
    mrv = 0;
    cycle();

    // reset mid-transaction, late response is stray
    dreq = 1; daddr = 32'h500; dwe = 0; dbe = 4'hF; mgnt = 1;
    cycle();
    check_eq("rst_dgr", 32'(obs_dgr), 32'd1);
    dreq = 0; rst_n = 0; ireq = 1; iaddr = 32'h800; mrdata = 32'hCAFE_F00D;
    cycle();
    check_eq("midrst_req", 32'(obs_req), 32'd0);
    check_eq("midrst_rdata", obs_irdata, 32'd0);
    cycle();
    rst_n = 1; ireq = 0; mrv = 1;
    cycle();
    check_eq("stray_irv", 32'(obs_irv), 32'd0);
    check_eq("stray_drv", 32'(obs_drv), 32'd0);
    mrv = 0; ireq = 1; iaddr = 32'h804;
    cycle();
    check_eq("post_rst_igr", 32'(obs_igr), 32'd1);
    ireq = 0; mrv = 1; mrdata = 32'h0BAD_CAFE;
    cycle();
    check_eq("post_rst_irv", 32'(obs_irv), 32'd1);
    mrv = 0;
    cycle();

    // random traffic against a variable-latency memory
    idle_inputs();
    ip = 0; dp = 0; mem_busy = 0; mem_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; iaddr = $urandom;
      end
      if (!dp && $urandom_range(0, 3) != 0) begin
        dp = 1; daddr = $urandom; dwe = 1'($urandom_range(0, 1));
        dbe = 4'($urandom); dwdata = $urandom;
      end
      ireq = ip; dreq = dp;
      mgnt = ($urandom_range(0, 3) != 0);
      mrv = mem_busy && (mem_cnt == 0);
      mrdata = $urandom;
      cycle();
      if (e_igr) ip = 0;
      if (e_dgr) dp = 0;
      if (mrv) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (e_igr || e_dgr) begin
        mem_busy = 1; mem_cnt = $urandom_range(0, 2);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-port, request/grant/response memory between instruction fetch and the load/store path of the riscv_cpu core. Sits between the fetch stage / LSU and the unified memory. Supports one outstanding transaction, with same-cycle reissue on response. Data has fixed priority, with a starvation guard so fetch always progresses during long load/store bursts.

## Interface
- MAX_DATA_BURST, 4: consecutive data grants allowed while fetch waits before fetch is forced to win; range 1..15
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; one clock; asynchronous, active-low
- instr_req_i, instr_addr_i[31:0]  in  1/32  fetch request, word address (fetch is read-only)
- instr_gnt_o, instr_rvalid_o  out  1/1  fetch address accepted / fetch response valid
- instr_rdata_o  out  32  fetch read data
- data_req_i, data_we_i, data_be_i[3:0], data_addr_i[31:0], data_wdata_i[31:0]  in  LSU request
- data_gnt_o, data_rvalid_o  out  1/1  LSU accepted / LSU response valid (reads and writes)
- data_rdata_o  out  32  LSU read data
- mem_req_o, mem_we_o, mem_be_o[3:0], mem_addr_o[31:0], mem_wdata_o[31:0]  out  memory request
- mem_gnt_i, mem_rvalid_i, mem_rdata_i[31:0]  in  memory grant / response / read data

## Operation
- Owner encoding: NONE, INSTR, DATA.
- State register: IDLE, or RESP (one transaction granted, awaiting mem_rvalid_i).
- **Issue allowed** when state=IDLE, or when state=RESP and mem_rvalid_i=1 (back-to-back).
- **Selection when issue is allowed**:
  - If lock_q is set, select lock_owner_q.
  - Else if data_req_i=1 and not (instr_req_i=1 and streak_q==MAX_DATA_BURST), select DATA.
  - Else if instr_req_i=1, select INSTR.
  - Else select NONE.
- **Memory request mux**:
  - mem_req_o=1 iff the selection is not NONE.
  - mem_addr/we/be/wdata come from the selected requester. For INSTR, we=0 and be=4'hF.
  - When mem_req_o=0, mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o are all 0.
- **Grant**:
  - instr_gnt_o = mem_req_o & mem_gnt_i & (sel==INSTR).
  - data_gnt_o = mem_req_o & mem_gnt_i & (sel==DATA).
- **Lock**:
  - If mem_req_o=1 and mem_gnt_i=0, set lock_q and lock_owner_q=sel. The request stays on that owner until granted, even if a higher-priority request appears.
  - Clear lock_q on grant.
  - Requesters hold req and payload stable until gnt.
- **On grant**: resp_owner_q <= sel; state <= RESP.
- **On mem_rvalid_i in RESP**:
  - Pulse the rvalid of resp_owner_q.
  - state <= RESP if a new grant occurs in the same cycle, else IDLE.
- **rdata**: instr_rdata_o and data_rdata_o both equal mem_rdata_i. Consumers qualify with their own rvalid.
- **Starvation counter streak_q** (4 bit):
  - +1 on a data grant while instr_req_i=1, saturating at MAX_DATA_BURST.
  - Cleared on an instr grant, or in any cycle with instr_req_i=0.
- **Stray response**: mem_rvalid_i in IDLE is discarded; no rvalid is forwarded and state is unchanged.

## Timing
- Reset values:
  - Registers: state=IDLE, lock_q=0, lock_owner_q=NONE, resp_owner_q=NONE, streak_q=0.
  - Outputs: all outputs 0.
- Grant and the request mux are combinational from req/gnt inputs: zero-cycle arbitration.
- Response: requester rvalid is combinational from mem_rvalid_i. Earliest response is the cycle after grant.
- Throughput: 1 transaction/cycle with single-cycle memory. Otherwise 1 per (memory latency) cycles.
- Simultaneous rvalid and new request: response is delivered to the old owner and the new grant to the new owner in the same cycle. Both may be the same requester.
- No request is issued in RESP without mem_rvalid_i; mem_req_o=0 then.
- Reset mid-transaction: return to IDLE immediately. A memory response arriving after reset is treated as stray.

## Test plan
- **Single fetch**:
  - Stimulus: instr_req_i=1, addr 0x100, mem_gnt_i=1 at cycle 0, mem_rvalid_i=1 with rdata 0x00500093 at cycle 2.
  - Response: instr_gnt_o=1 at cycle 0; instr_rvalid_o=1 only at cycle 2; data_rvalid_o stays 0.
- **Simultaneous requests**:
  - Stimulus: both requesters assert with immediate gnt; data is a store to 0x200, wdata 0xDEADBEEF, be 4'b0011.
  - Response: the memory sees we=1, be=4'b0011 first; the fetch is granted only after the store's rvalid.
- **Lock**:
  - Stimulus: instr_req_i alone, mem_gnt_i low for 3 cycles, data_req_i rises at cycle 1.
  - Response: mem_addr_o holds the fetch address for 3 cycles; the fetch is granted at cycle 3; data is granted afterwards.
- **Starvation**:
  - Stimulus: continuous data_req_i and instr_req_i, single-cycle memory, MAX_DATA_BURST=4.
  - Response: grant pattern is D,D,D,D,I repeating.
- **Back-to-back and reset**:
  - Stimulus: issue a data read, then assert rst_ni=0 before rvalid; release reset; then drive mem_rvalid_i=1.
  - Response: all outputs are 0 during reset; the late rvalid is forwarded to no one; a new fetch is granted normally afterwards.
